multi_channel_frequency_generator: RTL and testbench

- Parametrised successor to the single-channel frequency generator: CHANNELS independent counters, each producing a 50%-duty out_clk and a one-cycle out_pulse at every half-period boundary.
- Adds per-channel enable and glitch-free reload of the half-period value.
- Adds a burst mode that emits exactly N carrier periods and then signals done.
- Sits between the IR transmitter control logic and the IR LED drivers, generating carriers and timed bursts on several channels at once.

---
 rtl/multi_channel_frequency_generator.sv | 153 +++++++++++++++
 tb/tb_multi_channel_frequency_generator.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_frequency_generator.sv
// Multi-channel carrier generator: each channel divides sys_clk into a 50% duty clock
// with boundary strobes, and runs either free (enable level) or as a counted burst.
module multi_channel_frequency_generator #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                            sys_clk,
    input  logic                            reset,
    input  logic [CHANNELS-1:0]             enable,
    input  logic [CHANNELS-1:0]             start,
    input  logic [CHANNELS-1:0]             mode,
    input  logic [CHANNELS*WIDTH-1:0]       half_period,
    input  logic [CHANNELS*BURST_WIDTH-1:0] burst_len,
    output logic [CHANNELS-1:0]             out_clk,
    output logic [CHANNELS-1:0]             out_pulse,
    output logic [CHANNELS-1:0]             busy,
    output logic [CHANNELS-1:0]             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : gChan
        state_e                 state_q, state_d;
        logic [WIDTH-1:0]       count_q, count_d;
        logic [WIDTH-1:0]       shadowH_q, shadowH_d;
        logic [BURST_WIDTH-1:0] burstCnt_q, burstCnt_d;
        logic                   burstMode_q, burstMode_d;
        logic                   zeroPend_q, zeroPend_d;
        logic                   outClk_q, outClk_d;
        logic                   outPulse_q, outPulse_d;
        logic                   busy_q, busy_d;
        logic                   done_q, done_d;

        logic [WIDTH-1:0]       halfPeriod;
        logic [BURST_WIDTH-1:0] burstLen;
        logic                   terminal;
        logic                   freeRunStop;

        assign halfPeriod  = half_period[ch*WIDTH +: WIDTH];
        assign burstLen    = burst_len[ch*BURST_WIDTH +: BURST_WIDTH];
        assign terminal    = (count_q == shadowH_q);
        assign freeRunStop = (state_q == RUN) && !burstMode_q && !enable[ch];

        // A zero-length burst never leaves IDLE; zeroPend only delays its done strobe by one edge.
        always_comb begin
            state_d     = state_q;
            count_d     = count_q;
            shadowH_d   = shadowH_q;
            burstCnt_d  = burstCnt_q;
            burstMode_d = burstMode_q;
            zeroPend_d  = 1'b0;
            outClk_d    = outClk_q;
            outPulse_d  = 1'b0;
            done_d      = 1'b0;

            case (state_q)
                IDLE: begin
                    if (zeroPend_q) begin
                        done_d = 1'b1;
                    end else if (!mode[ch] && enable[ch]) begin
                        state_d     = RUN;
                        count_d     = '0;
                        shadowH_d   = halfPeriod;
                        burstMode_d = 1'b0;
                        burstCnt_d  = burstLen;
                    end else if (mode[ch] && start[ch]) begin
                        count_d     = '0;
                        shadowH_d   = halfPeriod;
                        burstMode_d = 1'b1;
                        burstCnt_d  = burstLen;
                        if (burstLen == '0) begin
                            zeroPend_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end

                RUN, DRAIN: begin
                    if (freeRunStop && !outClk_q) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        if (freeRunStop) begin
                            state_d = DRAIN;
                        end
                        if (terminal) begin
                            count_d    = '0;
                            outClk_d   = !outClk_q;
                            outPulse_d = 1'b1;
                            shadowH_d  = halfPeriod;
                            if (!outClk_q) begin
                                if (burstMode_q && (burstCnt_q != '0)) begin
                                    burstCnt_d = burstCnt_q - 1'b1;
                                end
                            end else if (freeRunStop || (state_q == DRAIN) ||
                                         (burstMode_q && (burstCnt_q == '0))) begin
                                state_d = IDLE;
                                done_d  = burstMode_q;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase

            busy_d = (state_d != IDLE);
        end

        always_ff @(posedge sys_clk or negedge reset) begin
            if (!reset) begin
                state_q     <= IDLE;
                count_q     <= '0;
                shadowH_q   <= '0;
                burstCnt_q  <= '0;
                burstMode_q <= 1'b0;
                zeroPend_q  <= 1'b0;
                outClk_q    <= 1'b0;
                outPulse_q  <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                count_q     <= count_d;
                shadowH_q   <= shadowH_d;
                burstCnt_q  <= burstCnt_d;
                burstMode_q <= burstMode_d;
                zeroPend_q  <= zeroPend_d;
                outClk_q    <= outClk_d;
                outPulse_q  <= outPulse_d;
                busy_q      <= busy_d;
                done_q      <= done_d;
            end
        end

        assign out_clk[ch]   = outClk_q;
        assign out_pulse[ch] = outPulse_q;
        assign busy[ch]      = busy_q;
        assign done[ch]      = done_q;
    end

endmodule

// File: tb/tb_multi_channel_frequency_generator.sv
// Bench for multi_channel_frequency_generator: timestamp-based reference model compared
// every cycle, plus directed scenarios pinned with hand-computed edge numbers.
module tb_multi_channel_frequency_generator;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int BW = 8;

    localparam bit [1:0] S_IDLE  = 2'd0;
    localparam bit [1:0] S_RUN   = 2'd1;
    localparam bit [1:0] S_DRAIN = 2'd2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [CH-1:0]     enable = '0;
    logic [CH-1:0]     start = '0;
    logic [CH-1:0]     mode = '0;
    logic [CH*W-1:0]   halfPeriod = '0;
    logic [CH*BW-1:0]  burstLen = '0;
    logic [CH-1:0]     outClk;
    logic [CH-1:0]     outPulse;
    logic [CH-1:0]     busy;
    logic [CH-1:0]     done;

    int checks = 0;
    int errors = 0;
    int edgeNo = 0;

    // Reference model: phases are tracked as absolute edge numbers of the next toggle.
    bit [1:0] mSt [CH];
    bit       mLvl [CH];
    bit       mPul [CH];
    bit       mDon [CH];
    bit       mBsy [CH];
    bit       mBurst [CH];
    bit       mZero [CH];
    int       mNext [CH];
    int       mLeft [CH];

    // Event logs of observed DUT behaviour, in edge numbers.
    int riseT [CH][32];
    int fallT [CH][32];
    int doneT [CH][32];
    int busyOnT [CH][32];
    int busyOffT [CH][32];
    int riseN [CH];
    int fallN [CH];
    int doneN [CH];
    int pulseN [CH];
    int busyOnN [CH];
    int busyOffN [CH];
    bit prevClk [CH];
    bit prevBusy [CH];

    bit spacingOn = 1'b0;
    int lastP [CH];
    int spCnt [CH];
    int expSp [CH] = '{11, 21, 51, 129};

    always #5 clk = ~clk;

    multi_channel_frequency_generator #(
        .CHANNELS   (CH),
        .WIDTH      (W),
        .BURST_WIDTH(BW)
    ) dut (
        .sys_clk    (clk),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .mode       (mode),
        .half_period(halfPeriod),
        .burst_len  (burstLen),
        .out_clk    (outClk),
        .out_pulse  (outPulse),
        .busy       (busy),
        .done       (done)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeNo);
        end
    endtask

    task automatic applyStimulus(input int c, input bit en, input bit st, input bit md,
                                 input int hp, input int bl);
        enable[c] = en;
        start[c]  = st;
        mode[c]   = md;
        halfPeriod[c*W +: W]  = hp[W-1:0];
        burstLen[c*BW +: BW]  = bl[BW-1:0];
    endtask

    task automatic clearLog();
        for (int c = 0; c < CH; c++) begin
            riseN[c] = 0; fallN[c] = 0; doneN[c] = 0; pulseN[c] = 0;
            busyOnN[c] = 0; busyOffN[c] = 0;
        end
    endtask

    task automatic modelStep(input int c);
        int hp;
        int bl;
        hp = int'(halfPeriod[c*W +: W]);
        bl = int'(burstLen[c*BW +: BW]);
        mPul[c] = 1'b0;
        mDon[c] = 1'b0;
        if (mSt[c] == S_IDLE) begin
            if (mZero[c]) begin
                mDon[c]  = 1'b1;
                mZero[c] = 1'b0;
            end else if (!mode[c] && enable[c]) begin
                mSt[c] = S_RUN; mBsy[c] = 1'b1; mLvl[c] = 1'b0; mBurst[c] = 1'b0;
                mNext[c] = edgeNo + hp + 1;
            end else if (mode[c] && start[c]) begin
                if (bl == 0) begin
                    mZero[c] = 1'b1;
                end else begin
                    mSt[c] = S_RUN; mBsy[c] = 1'b1; mLvl[c] = 1'b0; mBurst[c] = 1'b1;
                    mLeft[c] = bl;
                    mNext[c] = edgeNo + hp + 1;
                end
            end
        end else if (mSt[c] == S_RUN && !mBurst[c] && !enable[c] && !mLvl[c]) begin
            mSt[c]  = S_IDLE;
            mBsy[c] = 1'b0;
        end else begin
            if (mSt[c] == S_RUN && !mBurst[c] && !enable[c]) mSt[c] = S_DRAIN;
            if (edgeNo == mNext[c]) begin
                mPul[c]  = 1'b1;
                mLvl[c]  = !mLvl[c];
                mNext[c] = edgeNo + hp + 1;
                if (mLvl[c]) begin
                    if (mBurst[c]) mLeft[c] = mLeft[c] - 1;
                end else if (mSt[c] == S_DRAIN || (mBurst[c] && mLeft[c] == 0)) begin
                    mSt[c]  = S_IDLE;
                    mBsy[c] = 1'b0;
                    mDon[c] = mBurst[c];
                end
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CH; c++) begin
                mSt[c] = S_IDLE; mLvl[c] = 0; mPul[c] = 0; mDon[c] = 0; mBsy[c] = 0;
                mBurst[c] = 0; mZero[c] = 0; mNext[c] = 0; mLeft[c] = 0;
            end
        end else begin
            edgeNo++;
            for (int c = 0; c < CH; c++) modelStep(c);
        end
    end

    // Per-cycle comparison against the model, then event logging for the directed checks.
    always @(posedge clk) begin
        #2;
        for (int c = 0; c < CH; c++) begin
            checkOutput($sformatf("out_clk[%0d]", c), int'(outClk[c]), int'(mLvl[c]));
            checkOutput($sformatf("out_pulse[%0d]", c), int'(outPulse[c]), int'(mPul[c]));
            checkOutput($sformatf("busy[%0d]", c), int'(busy[c]), int'(mBsy[c]));
            checkOutput($sformatf("done[%0d]", c), int'(done[c]), int'(mDon[c]));

            if (outClk[c] && !prevClk[c] && riseN[c] < 32) riseT[c][riseN[c]++] = edgeNo;
            if (!outClk[c] && prevClk[c] && fallN[c] < 32) fallT[c][fallN[c]++] = edgeNo;
            if (done[c] && doneN[c] < 32) doneT[c][doneN[c]++] = edgeNo;
            if (busy[c] && !prevBusy[c] && busyOnN[c] < 32) busyOnT[c][busyOnN[c]++] = edgeNo;
            if (!busy[c] && prevBusy[c] && busyOffN[c] < 32) busyOffT[c][busyOffN[c]++] = edgeNo;
            if (outPulse[c]) pulseN[c]++;
            prevClk[c]  = outClk[c];
            prevBusy[c] = busy[c];

            if (spacingOn && outPulse[c]) begin
                if (lastP[c] >= 0) begin
                    checkOutput($sformatf("spacing[%0d]", c), edgeNo - lastP[c], expSp[c]);
                    spCnt[c]++;
                end
                lastP[c] = edgeNo;
            end
        end
    end

    task automatic waitRise(input int c, output int edgeAt);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (outClk[c] && outPulse[c]) seen = 1'b1;
        end
        checkOutput("waitRise", int'(seen), 1);
        edgeAt = edgeNo;
    endtask

    initial begin
        int s;
        int r;

        // Reset state
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_clk", int'(outClk), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        reset = 1'b1;
        @(negedge clk);

        // ch0 free-run H=4 for 20 periods
        clearLog();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 4, 0);
        s = edgeNo + 1;
        repeat (205) @(negedge clk);
        checkOutput("fr_first_rise", riseT[0][0] - s, 5);
        checkOutput("fr_first_fall", fallT[0][0] - s, 10);
        checkOutput("fr_rise20", riseT[0][19] - s, 195);
        checkOutput("fr_rise_cnt", riseN[0], 20);
        checkOutput("fr_pulse_cnt", pulseN[0], 40);

        // Reload H 4 -> 9 during a high phase
        waitRise(0, r);
        clearLog();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 9, 0);
        repeat (30) @(negedge clk);
        checkOutput("rl_fall", fallT[0][0] - r, 5);
        checkOutput("rl_rise", riseT[0][0] - r, 15);
        checkOutput("rl_fall2", fallT[0][1] - r, 25);

        // Drop enable 3 cycles into high phase, re-assert during drain, then drop in low phase
        waitRise(0, r);
        clearLog();
        repeat (2) @(negedge clk);
        enable[0] = 1'b0;
        repeat (3) @(negedge clk);
        enable[0] = 1'b1;
        repeat (9) @(negedge clk);
        enable[0] = 1'b0;
        repeat (16) @(negedge clk);
        checkOutput("dr_fall", fallT[0][0] - r, 10);
        checkOutput("dr_busy_off", busyOffT[0][0] - r, 10);
        checkOutput("dr_restart", busyOnT[0][0] - r, 11);
        checkOutput("low_stop", busyOffT[0][1] - r, 15);
        checkOutput("dr_pulses", pulseN[0], 1);
        checkOutput("low_no_rise", riseN[0], 0);

        // ch1 burst H=2 N=3, second start at edge 7 ignored
        clearLog();
        applyStimulus(1, 1'b0, 1'b1, 1'b1, 2, 3);
        s = edgeNo + 1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (6) @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("b_rise0", riseT[1][0] - s, 3);
        checkOutput("b_rise1", riseT[1][1] - s, 9);
        checkOutput("b_rise2", riseT[1][2] - s, 15);
        checkOutput("b_fall0", fallT[1][0] - s, 6);
        checkOutput("b_fall1", fallT[1][1] - s, 12);
        checkOutput("b_fall2", fallT[1][2] - s, 18);
        checkOutput("b_rise_cnt", riseN[1], 3);
        checkOutput("b_done", doneT[1][0] - s, 18);
        checkOutput("b_done_cnt", doneN[1], 1);
        checkOutput("b_busy_on", busyOnT[1][0] - s, 0);
        checkOutput("b_busy_off", busyOffT[1][0] - s, 18);

        // ch2 zero-length burst
        clearLog();
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 3, 0);
        s = edgeNo + 1;
        @(negedge clk);
        start[2] = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("z_done", doneT[2][0] - s, 1);
        checkOutput("z_done_cnt", doneN[2], 1);
        checkOutput("z_busy", busyOnN[2], 0);
        checkOutput("z_pulses", pulseN[2], 0);

        // All channels, reset mid-burst on ch3, then pulse spacing after release
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 10, 0);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 20, 0);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 50, 0);
        applyStimulus(3, 1'b0, 1'b1, 1'b1, 128, 5);
        repeat (300) @(negedge clk);
        checkOutput("mid_burst3", int'(busy[3]), 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_out_clk", int'(outClk), 0);
        checkOutput("arst_out_pulse", int'(outPulse), 0);
        checkOutput("arst_busy", int'(busy), 0);
        checkOutput("arst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < CH; c++) begin
            lastP[c] = -1;
            spCnt[c] = 0;
        end
        spacingOn = 1'b1;
        repeat (600) @(negedge clk);
        spacingOn = 1'b0;
        for (int c = 0; c < CH; c++) begin
            checkOutput($sformatf("sp_seen[%0d]", c), int'(spCnt[c] > 0), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
